// File: rtl/peripheral_bus_controller.sv
// Bridges the CPU native memory port to eight one-hot selected peripheral slots,
// with a per-transfer timeout and an enables sanity check so the CPU never hangs.
module peripheral_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_valid,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_wstrb,
  output logic         mem_ready,
  output logic [31:0]  mem_rdata,
  input  logic [7:0]   enables,
  output logic [7:0]   periph_valid,
  output logic [31:0]  periph_addr,
  output logic [31:0]  periph_wdata,
  output logic [3:0]   periph_wstrb,
  input  logic [7:0]   periph_ready,
  input  logic [255:0] periph_rdata,
  input  logic         err_clear,
  output logic         bus_error,
  output logic [31:0]  error_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        mem_ready_q;
  logic [31:0] mem_rdata_q;
  logic [7:0]  periph_valid_q;
  logic [31:0] periph_addr_q;
  logic [31:0] periph_wdata_q;
  logic [3:0]  periph_wstrb_q;
  logic        bus_error_q, bus_error_d;
  logic [31:0] error_addr_q;

  logic        enables_onehot;
  logic        accept;
  logic        bad_select;
  logic        sel_ready;
  logic        timeout_hit;
  logic        err_set;
  logic [31:0] sel_rdata;
  logic [31:0] slot_rdata_masked [8];

  assign enables_onehot = (enables != 8'd0) && ((enables & (enables - 8'd1)) == 8'd0);
  assign accept         = (state_q == ST_IDLE) && mem_valid && enables_onehot;
  assign bad_select     = (state_q == ST_IDLE) && mem_valid && !enables_onehot;

  // periph_valid_q is one-hot during ACCESS, so it doubles as the slot mask
  // and stray ready/data from unselected slots never reach the CPU.
  assign sel_ready   = |(periph_ready & periph_valid_q);
  assign timeout_hit = (state_q == ST_ACCESS) && !sel_ready && (cnt_q == CNT_LAST);
  assign err_set     = bad_select || timeout_hit;

  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    assign slot_rdata_masked[gi] = periph_rdata[32*gi +: 32] & {32{periph_valid_q[gi]}};
  end

  always_comb begin
    sel_rdata = 32'd0;
    for (int i = 0; i < 8; i++) begin
      sel_rdata = sel_rdata | slot_rdata_masked[i];
    end
  end

  // A new error in the same cycle as err_clear must remain visible.
  always_comb begin
    bus_error_d = bus_error_q;
    if (err_set) begin
      bus_error_d = 1'b1;
    end else if (err_clear) begin
      bus_error_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !sel_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mem_ready_q    <= 1'b0;
      mem_rdata_q    <= 32'd0;
      periph_valid_q <= 8'd0;
      periph_addr_q  <= 32'd0;
      periph_wdata_q <= 32'd0;
      periph_wstrb_q <= 4'd0;
      bus_error_q    <= 1'b0;
      error_addr_q   <= 32'd0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            periph_addr_q  <= mem_addr;
            periph_wdata_q <= mem_wdata;
            periph_wstrb_q <= mem_wstrb;
            periph_valid_q <= enables;
            state_q        <= ST_ACCESS;
          end else if (bad_select) begin
            mem_rdata_q  <= ERROR_DATA;
            error_addr_q <= mem_addr;
            mem_ready_q  <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            mem_rdata_q    <= (periph_wstrb_q == 4'd0) ? sel_rdata : 32'd0;
            periph_valid_q <= 8'd0;
            mem_ready_q    <= 1'b1;
            state_q        <= ST_DONE;
          end else if (timeout_hit) begin
            mem_rdata_q    <= ERROR_DATA;
            error_addr_q   <= periph_addr_q;
            periph_valid_q <= 8'd0;
            mem_ready_q    <= 1'b1;
            state_q        <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q        <= ST_IDLE;
          periph_valid_q <= 8'd0;
        end
      endcase
    end
  end

  assign mem_ready    = mem_ready_q;
  assign mem_rdata    = mem_rdata_q;
  assign periph_valid = periph_valid_q;
  assign periph_addr  = periph_addr_q;
  assign periph_wdata = periph_wdata_q;
  assign periph_wstrb = periph_wstrb_q;
  assign bus_error    = bus_error_q;
  assign error_addr   = error_addr_q;

endmodule
